// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher: FSM state encoding and the
// default values of the block parameters.
package pulse_stretcher_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_PEND_W = 4;
  localparam int DEF_GAP    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pulse_pend_ctr.sv
// pulse_pend_ctr
// Saturating up/down counter that holds the number of queued events.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   inc_i   in   one event to enqueue
//   dec_i   in   one event replayed (only asserted while cnt_o > 0)
//   cnt_o   out  current count (registered)
//   drop_o  out  an increment was refused because the count is saturated
module pulse_pend_ctr
  import pulse_stretcher_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              drop_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    drop_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) drop_o = 1'b1;
        else                  cnt_d  = cnt_q + 1'b1;
      end
      2'b01: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      // Simultaneous enqueue and replay cancel out, even when saturated,
      // so no event is dropped in that case.
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Stretches single-cycle event strobes into pulses of programmable width.
// Events arriving while a pulse or the inter-pulse gap is in progress are
// queued and replayed in order, separated by GAP low cycles.
// Optional feature macro: PULSE_STRETCHER_OVF_EN (adds ovf / ovf_clr).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   pulse_in  in   event strobe, one event per high cycle
//   width     in   pulse length in cycles (0 behaves as 1), sampled on entry to HIGH
//   out       out  stretched pulse (registered)
//   busy      out  high while not idle (registered)
//   pend_cnt  out  number of queued events
//   ovf       out  sticky flag, set one cycle after a dropped event (macro only)
//   ovf_clr   in   clears ovf; a simultaneous drop wins (macro only)
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PEND_W = DEF_PEND_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  width,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt
`ifdef PULSE_STRETCHER_OVF_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  ps_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_load;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             pend_inc, pend_dec;

  // The counter runs down to zero, so a pulse of W cycles loads W-1;
  // a zero width is promoted to a one-cycle pulse.
  assign width_load = (width == '0) ? '0 : (width - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The event that starts a pulse is consumed, not queued.
        if (pulse_in) begin
          state_d = ST_HIGH;
          cnt_d   = width_load;
        end
      end
      ST_HIGH: begin
        pend_inc = pulse_in;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        pend_inc = pulse_in;
        if (cnt_q == '0) begin
          if (pend_cnt != '0) begin
            pend_dec = 1'b1;
            state_d  = ST_HIGH;
            cnt_d    = width_load;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

`ifdef PULSE_STRETCHER_OVF_EN
  logic drop;
  logic ovf_q, ovf_d;

  pulse_pend_ctr #(.PEND_W(PEND_W)) u_pend (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (pend_inc),
    .dec_i  (pend_dec),
    .cnt_o  (pend_cnt),
    .drop_o (drop)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic drop_unused;

  pulse_pend_ctr #(.PEND_W(PEND_W)) u_pend (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (pend_inc),
    .dec_i  (pend_dec),
    .cnt_o  (pend_cnt),
    .drop_o (drop_unused)
  );
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with default parameters.
// "Cycle k" is the clock period following the k-th rising edge after the
// stimulus step starts; inputs change and outputs are sampled 1 time unit
// after the rising edge.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       pulse_in;
  logic [7:0] width;
  logic       out;
  logic       busy;
  logic [3:0] pend_cnt;
`ifdef PULSE_STRETCHER_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  int checks = 0;
  int errors = 0;

  pulse_stretcher dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .width    (width),
    .out      (out),
    .busy     (busy),
    .pend_cnt (pend_cnt)
`ifdef PULSE_STRETCHER_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rises;
    logic prev_out;

    rst      = 1'b1;
    pulse_in = 1'b0;
    width    = 8'd0;
`ifdef PULSE_STRETCHER_OVF_EN
    ovf_clr  = 1'b0;
`endif
    tick();
    tick();
    chk("reset out", 32'(out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pend", 32'(pend_cnt), 32'd0);
`ifdef PULSE_STRETCHER_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();
    tick();
    chk("idle out", 32'(out), 32'd0);

    // Single event, width 3: out 1..3, busy 1..4, idle from 5.
    width    = 8'd3;
    pulse_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      pulse_in = 1'b0;
      chk($sformatf("single out c%0d", c), 32'(out), 32'(c <= 3));
      chk($sformatf("single busy c%0d", c), 32'(busy), 32'(c <= 4));
    end

    // Zero width behaves as one cycle.
    width    = 8'd0;
    pulse_in = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      pulse_in = 1'b0;
      chk($sformatf("zero out c%0d", c), 32'(out), 32'(c == 1));
      chk($sformatf("zero busy c%0d", c), 32'(busy), 32'(c <= 2));
    end

    // Queued event: events at 0 and 2, width 3.
    width    = 8'd3;
    pulse_in = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      pulse_in = (c == 2);
      chk($sformatf("queue out c%0d", c), 32'(out),
          32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      chk($sformatf("queue pend c%0d", c), 32'(pend_cnt), 32'(c == 3 || c == 4));
      chk($sformatf("queue busy c%0d", c), 32'(busy), 32'(c <= 8));
    end

    // Width change mid-pulse: current pulse keeps 5, replay uses 2.
    width    = 8'd5;
    pulse_in = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      pulse_in = (c == 1);
      if (c == 2) width = 8'd2;
      chk($sformatf("wchg out c%0d", c), 32'(out),
          32'((c >= 1 && c <= 5) || c == 7 || c == 8));
      chk($sformatf("wchg busy c%0d", c), 32'(busy), 32'(c <= 9));
    end

    // Saturation: a 20-cycle first pulse keeps the block in HIGH while
    // pulse_in is held for cycles 0-19, so no replay drains the queue:
    // 19 events queue, 15 are kept, 4 are dropped, 16 pulses in total.
    width    = 8'd20;
    pulse_in = 1'b1;
    rises    = 0;
    prev_out = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) width = 8'd1;
      if (c == 20) pulse_in = 1'b0;
      if (out && !prev_out) rises++;
      prev_out = out;
      chk($sformatf("sat pend c%0d", c), 32'(pend_cnt), 32'((c - 1) > 15 ? 15 : (c - 1)));
`ifdef PULSE_STRETCHER_OVF_EN
      chk($sformatf("sat ovf c%0d", c), 32'(ovf), 32'(c >= 17));
`endif
    end
    for (int n = 0; n < 300 && busy; n++) begin
      tick();
      if (out && !prev_out) rises++;
      prev_out = out;
    end
    chk("sat pulses", 32'(rises), 32'd16);
    chk("sat drained busy", 32'(busy), 32'd0);
    chk("sat drained pend", 32'(pend_cnt), 32'd0);
`ifdef PULSE_STRETCHER_OVF_EN
    chk("ovf sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf cleared", 32'(ovf), 32'd0);
`endif

    // Reset mid-HIGH with three queued events.
    width    = 8'd5;
    pulse_in = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      pulse_in = (c <= 3);
    end
    chk("pre-rst pend", 32'(pend_cnt), 32'd3);
    chk("pre-rst out", 32'(out), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst out", 32'(out), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst pend", 32'(pend_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("post-rst out c%0d", c), 32'(out), 32'd0);
      chk($sformatf("post-rst busy c%0d", c), 32'(busy), 32'd0);
    end
    // A fresh event after reset rises after exactly one cycle.
    width    = 8'd1;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk("fresh out", 32'(out), 32'd1);
    tick();
    chk("fresh out low", 32'(out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
